// File: rtl/mem_bus_stage.sv
// MEM stage of the 5-stage MIPS pipeline: passes ALU results through and runs a
// request/ack data-bus transaction for loads and stores, stalling the pipe until done.
module mem_bus_stage #(
  parameter int unsigned MEMOP_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [5:0]         stall,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        hi_i,
  input  logic [31:0]        lo_i,
  input  logic               whilo_i,
  input  logic [MEMOP_W-1:0] mem_op_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        reg2_i,
  output logic [4:0]         mem_wd,
  output logic               mem_wreg,
  output logic [31:0]        mem_wdata,
  output logic [31:0]        mem_hi,
  output logic [31:0]        mem_lo,
  output logic               mem_whilo,
  output logic               stallreq,
  output logic               misalign,
  output logic               bus_req,
  output logic               bus_we,
  output logic [31:0]        bus_addr,
  output logic [3:0]         bus_sel,
  output logic [31:0]        bus_wdata,
  input  logic               bus_ack,
  input  logic [31:0]        bus_rdata
);

  localparam logic [MEMOP_W-1:0] OpLb  = MEMOP_W'(1);
  localparam logic [MEMOP_W-1:0] OpLbu = MEMOP_W'(2);
  localparam logic [MEMOP_W-1:0] OpLh  = MEMOP_W'(3);
  localparam logic [MEMOP_W-1:0] OpLhu = MEMOP_W'(4);
  localparam logic [MEMOP_W-1:0] OpLw  = MEMOP_W'(5);
  localparam logic [MEMOP_W-1:0] OpSb  = MEMOP_W'(9);
  localparam logic [MEMOP_W-1:0] OpSh  = MEMOP_W'(10);
  localparam logic [MEMOP_W-1:0] OpSw  = MEMOP_W'(11);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state;
  logic [31:0] rd_buf;

  logic        is_load, is_store, is_byte, is_half, is_word, mis_c;
  logic [3:0]  sel_c;
  logic [31:0] st_data, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_op_i)
      OpLb, OpLbu: begin is_load  = 1'b1; is_byte = 1'b1; end
      OpLh, OpLhu: begin is_load  = 1'b1; is_half = 1'b1; end
      OpLw:        begin is_load  = 1'b1; is_word = 1'b1; end
      OpSb:        begin is_store = 1'b1; is_byte = 1'b1; end
      OpSh:        begin is_store = 1'b1; is_half = 1'b1; end
      OpSw:        begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign mis_c = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));

  // Big-endian lanes: address 0 maps to the most significant byte.
  always_comb begin
    sel_c   = 4'b1111;
    st_data = reg2_i;
    if (is_byte) begin
      st_data = {4{reg2_i[7:0]}};
      case (mem_addr_i[1:0])
        2'b00:   sel_c = 4'b1000;
        2'b01:   sel_c = 4'b0100;
        2'b10:   sel_c = 4'b0010;
        default: sel_c = 4'b0001;
      endcase
    end else if (is_half) begin
      st_data = {2{reg2_i[15:0]}};
      sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
  end

  always_comb begin
    case (mem_addr_i[1:0])
      2'b00:   ld_byte = rd_buf[31:24];
      2'b01:   ld_byte = rd_buf[23:16];
      2'b10:   ld_byte = rd_buf[15:8];
      default: ld_byte = rd_buf[7:0];
    endcase
    ld_half = mem_addr_i[1] ? rd_buf[15:0] : rd_buf[31:16];
    case (mem_op_i)
      OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   ld_data = {24'b0, ld_byte};
      OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
      OpLhu:   ld_data = {16'b0, ld_half};
      default: ld_data = rd_buf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= StIdle;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'b0;
      bus_sel   <= 4'b0;
      bus_wdata <= 32'b0;
      rd_buf    <= 32'b0;
    end else begin
      case (state)
        StIdle: begin
          if ((is_load | is_store) & ~mis_c) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr_i[31:2], 2'b00};
            bus_sel   <= sel_c;
            bus_wdata <= st_data;
            state     <= StBusy;
          end
        end
        StBusy: begin
          if (bus_ack) begin
            rd_buf  <= bus_rdata;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            state   <= StDone;
          end
        end
        StDone: begin
          // Leaving only when the pipe advances keeps the held instruction from relaunching.
          if (!stall[4]) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_hi    = hi_i;
    mem_lo    = lo_i;
    misalign  = mis_c;
    mem_wd    = wd_i;
    mem_wreg  = wreg_i;
    mem_wdata = wdata_i;
    mem_whilo = whilo_i;
    stallreq  = 1'b0;
    if (is_load | is_store) begin
      if (state == StDone && !mis_c) begin
        if (is_load) mem_wdata = ld_data;
      end else begin
        mem_wd    = 5'b0;
        mem_wreg  = 1'b0;
        mem_wdata = 32'b0;
        mem_whilo = 1'b0;
        stallreq  = ~mis_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Randomized bench for mem_bus_stage: a transaction-level model predicts every
// cycle's outputs, plus literal checks pinning the directed scenarios.
module tb_mem_bus_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic [5:0]  stall;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo, stallreq, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_bus_stage #(.MEMOP_W(4)) dut (
    .clk(clk), .clr(clr), .stall(stall), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .stallreq(stallreq),
    .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected values for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        e_stallreq, e_misalign, e_bus_req, e_bus_chk, e_wdata_chk, e_done;
  logic [4:0]  e_wd;
  logic        e_wreg, e_whilo, e_bus_we;
  logic [31:0] e_wdata, e_bus_addr, e_bus_wdata;
  logic [3:0]  e_bus_sel;

  // Snapshots for the literal checks.
  logic [4:0]  snap_wd;
  logic        snap_wreg, snap_stallreq, snap_bus_req, snap_misalign, last_we;
  logic [31:0] snap_wdata, done_wdata, last_addr, last_wdata;
  logic [3:0]  last_sel;
  int          stall_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_load(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {4'd9, 4'd10, 4'd11};
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [31:0] a);
    if (op inside {4'd3, 4'd4, 4'd10}) return a % 2 != 0;
    if (op inside {4'd5, 4'd11}) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] s;
    s = 4'b1000;
    if (op inside {4'd1, 4'd2, 4'd9}) return s >> (a % 4);
    if (op inside {4'd3, 4'd4, 4'd10}) return ((a % 4) >= 2) ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] r);
    if (op == 4'd9) return (r & 32'hFF) * 32'h01010101;
    if (op == 4'd10) return (r & 32'hFFFF) * 32'h00010001;
    return r;
  endfunction

  function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] w);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    if (op == 4'd1 || op == 4'd2) begin
      v = (w >> (8 * (3 - off))) & 32'hFF;
      if (op == 4'd1 && v >= 32'h80) v = v | 32'hFFFFFF00;
      return v;
    end
    if (op == 4'd3 || op == 4'd4) begin
      v = (w >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      if (op == 4'd3 && v >= 32'h8000) v = v | 32'hFFFF0000;
      return v;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallreq", 32'(stallreq), 32'(e_stallreq));
      chk("misalign", 32'(misalign), 32'(e_misalign));
      chk("mem_wd", 32'(mem_wd), 32'(e_wd));
      chk("mem_wreg", 32'(mem_wreg), 32'(e_wreg));
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_whilo", 32'(mem_whilo), 32'(e_whilo));
      chk("mem_hi", mem_hi, hi_i);
      chk("mem_lo", mem_lo, lo_i);
      chk("bus_req", 32'(bus_req), 32'(e_bus_req));
      if (e_bus_chk) begin
        chk("bus_we", 32'(bus_we), 32'(e_bus_we));
        chk("bus_addr", bus_addr, e_bus_addr);
        chk("bus_sel", 32'(bus_sel), 32'(e_bus_sel));
      end
      if (e_wdata_chk) chk("bus_wdata", bus_wdata, e_bus_wdata);
    end
    snap_wd       = mem_wd;
    snap_wreg     = mem_wreg;
    snap_wdata    = mem_wdata;
    snap_stallreq = stallreq;
    snap_bus_req  = bus_req;
    snap_misalign = misalign;
    if (stallreq) stall_cnt++;
    if (bus_req) begin
      last_we    = bus_we;
      last_addr  = bus_addr;
      last_sel   = bus_sel;
      last_wdata = bus_wdata;
    end
    if (e_done) done_wdata = mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction through the stage; clr_at < 0 means no flush.
  task automatic run_instr(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic whilo, input int dly, input int hold, input int clr_at,
                           input logic [31:0] rdata);
    logic ld, st, mis;
    ld  = is_load(op);
    st  = is_store(op);
    mis = misaligned(op, addr);
    mem_op_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; whilo_i = whilo; hi_i = $urandom; lo_i = $urandom;
    stall = 6'($urandom);
    e_done = 1'b0; e_bus_chk = 1'b0; e_wdata_chk = 1'b0; e_bus_req = 1'b0;
    e_misalign = mis;
    if (!(ld || st) || mis) begin
      e_stallreq = 1'b0;
      e_wd    = mis ? 5'd0 : wd;
      e_wreg  = mis ? 1'b0 : wreg;
      e_wdata = mis ? 32'd0 : wdata;
      e_whilo = mis ? 1'b0 : whilo;
      step();
      return;
    end
    e_stallreq = 1'b1; e_wd = 5'd0; e_wreg = 1'b0; e_wdata = 32'd0; e_whilo = 1'b0;
    stall[4] = 1'b1; bus_ack = 1'b0; clr = (clr_at == 0);
    step();
    if (clr_at == 0) begin clr = 1'b0; return; end
    e_bus_req = 1'b1; e_bus_chk = 1'b1; e_bus_we = st; e_bus_addr = addr & 32'hFFFFFFFC;
    e_bus_sel = lane_sel(op, addr); e_wdata_chk = st; e_bus_wdata = store_data(op, reg2);
    for (int k = 1; k <= dly; k++) begin
      bus_ack   = (k == dly);
      bus_rdata = (k == dly) ? rdata : $urandom;
      clr       = (k == clr_at);
      step();
      bus_ack = 1'b0;
      if (clr) begin clr = 1'b0; return; end
    end
    e_bus_req = 1'b0; e_bus_chk = 1'b0; e_wdata_chk = 1'b0;
    e_stallreq = 1'b0; e_wd = wd; e_wreg = wreg; e_whilo = whilo;
    e_wdata = ld ? load_value(op, addr, rdata) : wdata;
    e_done = 1'b1;
    for (int j = 0; j <= hold; j++) begin
      stall[4]  = (j < hold);
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      step();
    end
    bus_ack = 1'b0;
    e_done  = 1'b0;
  endtask

  initial begin
    clr = 1'b1; stall = 6'd0; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; hi_i = 32'd0;
    lo_i = 32'd0; whilo_i = 1'b0; mem_op_i = 4'd0; mem_addr_i = 32'd0; reg2_i = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0; e_done = 1'b0; stall_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    // Reset state of the registered bus outputs.
    e_stallreq = 1'b0; e_misalign = 1'b0; e_wd = 5'd0; e_wreg = 1'b0; e_wdata = 32'd0;
    e_whilo = 1'b0; e_bus_req = 1'b0; e_bus_chk = 1'b1; e_bus_we = 1'b0; e_bus_addr = 32'd0;
    e_bus_sel = 4'd0; e_wdata_chk = 1'b1; e_bus_wdata = 32'd0;
    chk_en = 1'b1;
    step();

    chk("model_lb", load_value(4'd1, 32'h101, 32'h00F40000), 32'hFFFFFFF4);
    chk("model_lhu", load_value(4'd4, 32'h102, 32'h1234ABCD), 32'h0000ABCD);
    chk("model_sel", 32'(lane_sel(4'd1, 32'h101)), 32'h4);
    chk("model_sh", store_data(4'd10, 32'hAAAA5678), 32'h56785678);

    run_instr(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 1'b0, 1, 0, -1, 32'h0);
    chk("alu_wd", 32'(snap_wd), 32'd3);
    chk("alu_wdata", snap_wdata, 32'h1234);
    chk("alu_stallreq", 32'(snap_stallreq), 32'd0);
    chk("alu_bus_req", 32'(snap_bus_req), 32'd0);

    stall_cnt = 0;
    run_instr(4'd1, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0, 1, 0, -1, 32'h00F40000);
    chk("lb_wdata", done_wdata, 32'hFFFFFFF4);
    chk("lb_addr", last_addr, 32'h100);
    chk("lb_sel", 32'(last_sel), 32'h4);
    chk("lb_we", 32'(last_we), 32'd0);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd2);

    run_instr(4'd2, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0, 1, 0, -1, 32'h00F40000);
    chk("lbu_wdata", done_wdata, 32'h000000F4);

    run_instr(4'd10, 32'h202, 32'hAAAA5678, 5'd0, 1'b0, 32'h55, 1'b0, 1, 0, -1, 32'h0);
    chk("sh_we", 32'(last_we), 32'd1);
    chk("sh_sel", 32'(last_sel), 32'h3);
    chk("sh_wdata", last_wdata, 32'h56785678);
    chk("sh_addr", last_addr, 32'h200);

    stall_cnt = 0;
    run_instr(4'd5, 32'h3F0, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0, 4, 0, -1, 32'hDEADBEEF);
    chk("lw_wait_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("lw_wait_wdata", done_wdata, 32'hDEADBEEF);

    run_instr(4'd3, 32'h3F2, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0, 1, 2, -1, 32'h1234F00D);
    chk("held_wdata", done_wdata, 32'hFFFFF00D);

    run_instr(4'd5, 32'h302, 32'h0, 5'd9, 1'b1, 32'h77, 1'b0, 1, 0, -1, 32'h0);
    chk("mis_flag", 32'(snap_misalign), 32'd1);
    chk("mis_bus_req", 32'(snap_bus_req), 32'd0);
    chk("mis_wreg", 32'(snap_wreg), 32'd0);
    chk("mis_stallreq", 32'(snap_stallreq), 32'd0);

    run_instr(4'd5, 32'h400, 32'h0, 5'd9, 1'b1, 32'h0, 1'b0, 3, 0, 2, 32'h11111111);
    bus_ack = 1'b1;
    run_instr(4'd0, 32'h0, 32'h0, 5'd1, 1'b1, 32'hABC, 1'b0, 1, 0, -1, 32'h0);
    bus_ack = 1'b0;
    chk("flush_bus_req", 32'(snap_bus_req), 32'd0);
    chk("flush_stallreq", 32'(snap_stallreq), 32'd0);
    run_instr(4'd1, 32'h401, 32'h0, 5'd2, 1'b1, 32'h0, 1'b0, 1, 0, -1, 32'h00800000);
    chk("after_flush_lb", done_wdata, 32'hFFFFFF80);

    // Flush coinciding with the ack, then flush at launch.
    run_instr(4'd4, 32'h500, 32'h0, 5'd2, 1'b1, 32'h0, 1'b0, 2, 0, 2, 32'h0);
    run_instr(4'd11, 32'h504, 32'hCAFE0001, 5'd2, 1'b0, 32'h9, 1'b0, 1, 0, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      int d, c;
      op = 4'($urandom);
      d  = int'($urandom_range(1, 4));
      c  = ($urandom % 10 == 0) ? int'($urandom_range(0, d)) : -1;
      run_instr(op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
                d, int'($urandom_range(0, 2)), c, $urandom);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
